// File: rtl/oflow_core_sched_pkg.sv
// Shared constants, scheduler state encoding and set-size helpers for the
// oflow_core set scheduler.
package oflow_core_sched_pkg;

  localparam int PE_NUM     = 24;
  localparam int SET_LEN    = 4;
  localparam int BBOX_LEN   = 9;
  localparam int MAX_BBOXES = 256;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START_SET,
    WAIT_PE,
    REG,
    FRAME_DONE
  } sched_state_t;

  function automatic logic [SET_LEN-1:0] ceil_div_pe(input logic [BBOX_LEN-1:0] n);
    int q;
    q = (int'(n) + PE_NUM - 1) / PE_NUM;
    return q[SET_LEN-1:0];
  endfunction

  // Bboxes handled by the next set: min(remain, PE_NUM).
  function automatic logic [BBOX_LEN-1:0] set_size(input logic [BBOX_LEN-1:0] remain);
    return (remain > BBOX_LEN'(PE_NUM)) ? BBOX_LEN'(PE_NUM) : remain;
  endfunction

  function automatic logic [PE_NUM-1:0] pe_mask(input logic [BBOX_LEN-1:0] cnt);
    logic [PE_NUM-1:0] m;
    for (int i = 0; i < PE_NUM; i++) m[i] = (i < int'(cnt));
    return m;
  endfunction

endpackage

// File: rtl/oflow_core_set_scheduler_collector.sv
// Sticky per-PE done register; all_done also sees bits arriving this cycle so
// the scheduler can leave WAIT_PE without an extra cycle.
module oflow_pe_done_collector
  import oflow_core_sched_pkg::*;
(
  input  logic              clk,
  input  logic              reset_N,
  input  logic              clear,
  input  logic [PE_NUM-1:0] mask,
  input  logic [PE_NUM-1:0] done_pe,
  output logic              all_done
);

  logic [PE_NUM-1:0] sticky;

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N)   sticky <= '0;
    else if (clear) sticky <= '0;
    else            sticky <= sticky | (done_pe & mask);
  end

  assign all_done = ((sticky | (done_pe & mask)) == mask);

endmodule

// File: rtl/oflow_core_set_scheduler.sv
// Steps one frame of bboxes through the PE array a set at a time: fire PEs,
// collect their done flags, hand the set to registration, repeat.
//
// state      | meaning
// IDLE       | waiting for start_frame
// LOAD       | latch frame size, compute num_of_sets
// START_SET  | start_pe pulse, mask valid, sticky done cleared
// WAIT_PE    | accumulate done_pe until every active PE reported
// REG        | start_registration pulsed, wait for done_registration
// FRAME_DONE | frame_done pulse, mask cleared
module oflow_core_set_scheduler
  import oflow_core_sched_pkg::*;
(
  input  logic                clk,
  input  logic                reset_N,
  input  logic                start_frame,
  input  logic [BBOX_LEN-1:0] num_of_bboxes_in_frame,
  input  logic                frame_abort,
  input  logic [PE_NUM-1:0]   done_pe,
  input  logic                done_registration,
  output logic                start_pe,
  output logic [PE_NUM-1:0]   active_pe_mask,
  output logic                start_registration,
  output logic [SET_LEN-1:0]  set_index,
  output logic [SET_LEN-1:0]  num_of_sets,
  output logic [BBOX_LEN-1:0] counter_of_remain_bboxes,
  output logic                busy,
  output logic                frame_done
);

  sched_state_t        state;
  logic [BBOX_LEN-1:0] n_lat;
  logic [BBOX_LEN-1:0] n_sat;
  logic [BBOX_LEN-1:0] set_bboxes;
  logic [BBOX_LEN-1:0] remain_next;
  logic [PE_NUM-1:0]   done_pe_live;
  logic                collect_clear;
  logic                all_done;

  assign n_sat = (num_of_bboxes_in_frame > BBOX_LEN'(MAX_BBOXES)) ?
                 BBOX_LEN'(MAX_BBOXES) : num_of_bboxes_in_frame;
  assign set_bboxes    = set_size(counter_of_remain_bboxes);
  assign remain_next   = counter_of_remain_bboxes - set_bboxes;
  assign collect_clear = (state == START_SET);
  assign done_pe_live  = (state == WAIT_PE) ? done_pe : '0;

  oflow_pe_done_collector u_collector (
    .clk      (clk),
    .reset_N  (reset_N),
    .clear    (collect_clear),
    .mask     (active_pe_mask),
    .done_pe  (done_pe_live),
    .all_done (all_done)
  );

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      state                    <= IDLE;
      n_lat                    <= '0;
      start_pe                 <= 1'b0;
      active_pe_mask           <= '0;
      start_registration       <= 1'b0;
      set_index                <= '0;
      num_of_sets              <= '0;
      counter_of_remain_bboxes <= '0;
      busy                     <= 1'b0;
      frame_done               <= 1'b0;
    end else begin
      start_pe           <= 1'b0;
      start_registration <= 1'b0;
      frame_done         <= 1'b0;
      if (frame_abort) begin
        state          <= IDLE;
        busy           <= 1'b0;
        active_pe_mask <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start_frame) begin
              n_lat <= n_sat;
              state <= LOAD;
              busy  <= 1'b1;
            end
          end
          LOAD: begin
            num_of_sets              <= ceil_div_pe(n_lat);
            counter_of_remain_bboxes <= n_lat;
            set_index                <= '0;
            if (n_lat == '0) begin
              state      <= FRAME_DONE;
              frame_done <= 1'b1;
            end else begin
              state          <= START_SET;
              start_pe       <= 1'b1;
              active_pe_mask <= pe_mask(set_size(n_lat));
            end
          end
          START_SET: state <= WAIT_PE;
          WAIT_PE: begin
            if (all_done) begin
              state              <= REG;
              start_registration <= 1'b1;
            end
          end
          REG: begin
            if (done_registration) begin
              counter_of_remain_bboxes <= remain_next;
              // set_index stays on the last set so it never reaches num_of_sets while busy
              if (remain_next == '0) begin
                state          <= FRAME_DONE;
                frame_done     <= 1'b1;
                active_pe_mask <= '0;
              end else begin
                state          <= START_SET;
                start_pe       <= 1'b1;
                set_index      <= set_index + SET_LEN'(1);
                active_pe_mask <= pe_mask(set_size(remain_next));
              end
            end
          end
          FRAME_DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_oflow_core_set_scheduler.sv
// Randomized bench for the set scheduler against a frame-level model of how
// bboxes split into sets of 24.
module tb_oflow_core_set_scheduler;

  logic        clk = 1'b0;
  logic        reset_N = 1'b0;
  logic        start_frame = 1'b0;
  logic [8:0]  num_of_bboxes_in_frame = '0;
  logic        frame_abort = 1'b0;
  logic [23:0] done_pe = '0;
  logic        done_registration = 1'b0;
  logic        start_pe;
  logic [23:0] active_pe_mask;
  logic        start_registration;
  logic [3:0]  set_index;
  logic [3:0]  num_of_sets;
  logic [8:0]  counter_of_remain_bboxes;
  logic        busy;
  logic        frame_done;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  oflow_core_set_scheduler dut (
    .clk                      (clk),
    .reset_N                  (reset_N),
    .start_frame              (start_frame),
    .num_of_bboxes_in_frame   (num_of_bboxes_in_frame),
    .frame_abort              (frame_abort),
    .done_pe                  (done_pe),
    .done_registration        (done_registration),
    .start_pe                 (start_pe),
    .active_pe_mask           (active_pe_mask),
    .start_registration       (start_registration),
    .set_index                (set_index),
    .num_of_sets              (num_of_sets),
    .counter_of_remain_bboxes (counter_of_remain_bboxes),
    .busy                     (busy),
    .frame_done               (frame_done)
  );

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // mode 0: random done_pe; 1: one bit per cycle in order; 2: PE5 then PE0
  task automatic run_frame(input int n, input int mode, input int abort_set);
    int          nn, sets, rem, size, outstanding, iter, dly;
    logic [23:0] mask, pick;
    bit          seen [24];
    nn   = (n > 256) ? 256 : n;
    sets = (nn + 23) / 24;
    @(negedge clk);
    start_frame = 1'b1;
    num_of_bboxes_in_frame = 9'(n);
    @(negedge clk);
    start_frame = 1'b0;
    num_of_bboxes_in_frame = 9'($urandom);
    chk_eq("load_busy", 32'(busy), 32'd1);
    chk_eq("load_no_start_pe", 32'(start_pe), 32'd0);
    @(negedge clk);
    chk_eq("num_of_sets", 32'(num_of_sets), 32'(sets));
    if (nn == 0) begin
      chk_eq("empty_frame_done", 32'(frame_done), 32'd1);
      chk_eq("empty_no_start_pe", 32'(start_pe), 32'd0);
      chk_eq("empty_busy", 32'(busy), 32'd1);
      @(negedge clk);
      chk_eq("empty_idle_busy", 32'(busy), 32'd0);
      chk_eq("empty_frame_done_pulse", 32'(frame_done), 32'd0);
      return;
    end
    for (int s = 0; s < sets; s++) begin
      rem  = nn - 24 * s;
      size = (rem > 24) ? 24 : rem;
      mask = 24'((32'd1 << size) - 1);
      chk_eq("start_pe", 32'(start_pe), 32'd1);
      chk_eq("mask", 32'(active_pe_mask), 32'(mask));
      chk_eq("set_index", 32'(set_index), 32'(s));
      chk_eq("remain", 32'(counter_of_remain_bboxes), 32'(rem));
      chk_eq("frame_done_mid", 32'(frame_done), 32'd0);
      // done flags seen while the set is being started must not count
      done_pe = 24'($urandom);
      done_registration = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk_eq("start_pe_pulse", 32'(start_pe), 32'd0);
      if (s == abort_set) begin
        frame_abort = 1'b1;
        done_pe = 24'($urandom);
        done_registration = 1'b1;
        @(negedge clk);
        frame_abort = 1'b0;
        done_pe = '0;
        done_registration = 1'b0;
        chk_eq("abort_busy", 32'(busy), 32'd0);
        chk_eq("abort_mask", 32'(active_pe_mask), 32'd0);
        chk_eq("abort_pulses", 32'({start_pe, start_registration, frame_done}), 32'd0);
        chk_eq("abort_remain", 32'(counter_of_remain_bboxes), 32'(rem));
        chk_eq("abort_set_index", 32'(set_index), 32'(s));
        @(negedge clk);
        chk_eq("abort_stays_idle", 32'({busy, frame_done, start_pe}), 32'd0);
        return;
      end
      for (int i = 0; i < 24; i++) seen[i] = 1'b0;
      outstanding = size;
      iter = 0;
      do begin
        case (mode)
          1:       pick = 24'(32'd1 << (iter % 24));
          2:       pick = (iter == 0) ? 24'h000020 : 24'h000001;
          default: pick = (iter >= 30) ? 24'hFFFFFF :
                          (24'($urandom) & 24'($urandom) & 24'($urandom));
        endcase
        done_pe = pick;
        done_registration = 1'($urandom_range(0, 1));
        start_frame = (mode != 0) || ($urandom_range(0, 3) == 0);
        num_of_bboxes_in_frame = 9'($urandom);
        for (int i = 0; i < size; i++)
          if (pick[i] && !seen[i]) begin
            seen[i] = 1'b1;
            outstanding--;
          end
        @(negedge clk);
        start_frame = 1'b0;
        chk_eq("start_registration", 32'(start_registration), 32'(outstanding == 0));
        chk_eq("held_mask", 32'(active_pe_mask), 32'(mask));
        chk_eq("held_set_index", 32'(set_index), 32'(s));
        chk_eq("wait_no_start_pe", 32'(start_pe), 32'd0);
        iter++;
      end while (outstanding > 0);
      done_pe = 24'($urandom);
      done_registration = 1'b0;
      dly = $urandom_range(0, 3);
      repeat (dly) begin
        @(negedge clk);
        chk_eq("reg_wait_pulses", 32'({start_pe, start_registration, frame_done}), 32'd0);
        chk_eq("reg_mask_held", 32'(active_pe_mask), 32'(mask));
      end
      done_registration = 1'b1;
      @(negedge clk);
      done_registration = 1'b0;
      done_pe = '0;
      if (s == sets - 1) begin
        chk_eq("end_frame_done", 32'(frame_done), 32'd1);
        chk_eq("end_mask", 32'(active_pe_mask), 32'd0);
        chk_eq("end_remain", 32'(counter_of_remain_bboxes), 32'd0);
        chk_eq("end_set_index", 32'(set_index), 32'(sets - 1));
        chk_eq("end_busy", 32'(busy), 32'd1);
        chk_eq("end_no_start_pe", 32'(start_pe), 32'd0);
        @(negedge clk);
        chk_eq("idle_busy", 32'(busy), 32'd0);
        chk_eq("frame_done_pulse", 32'(frame_done), 32'd0);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk_eq("reset_outputs", 32'({start_pe, start_registration, busy, frame_done}), 32'd0);
    chk_eq("reset_mask", 32'(active_pe_mask), 32'd0);
    chk_eq("reset_counters", 32'({set_index, num_of_sets, counter_of_remain_bboxes}), 32'd0);
    reset_N = 1'b1;
    repeat (2) @(negedge clk);

    run_frame(48, 0, -1);
    run_frame(256, 0, -1);
    run_frame(1, 2, -1);
    run_frame(0, 0, -1);
    run_frame(300, 0, -1);
    run_frame(24, 1, -1);
    run_frame(72, 0, 1);
    run_frame(24, 0, -1);
    for (int f = 0; f < 10; f++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_frame($urandom_range(0, 300), 0, -1);
    end

    // asynchronous reset while a set sits in REG
    @(negedge clk);
    start_frame = 1'b1;
    num_of_bboxes_in_frame = 9'd48;
    @(negedge clk);
    start_frame = 1'b0;
    @(negedge clk);
    done_pe = 24'hFFFFFF;
    @(negedge clk);
    @(negedge clk);
    chk_eq("pre_reset_start_registration", 32'(start_registration), 32'd1);
    #2 reset_N = 1'b0;
    #1;
    chk_eq("async_reset_pulses", 32'({start_pe, start_registration, busy, frame_done}), 32'd0);
    chk_eq("async_reset_mask", 32'(active_pe_mask), 32'd0);
    chk_eq("async_reset_counters", 32'({set_index, num_of_sets, counter_of_remain_bboxes}), 32'd0);
    done_pe = '0;
    @(negedge clk);
    reset_N = 1'b1;
    @(negedge clk);
    chk_eq("post_reset_no_frame_done", 32'({busy, frame_done}), 32'd0);
    run_frame(48, 0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/oflow_core_set_scheduler.md
Name: oflow_core_set_scheduler

Overview:
- Sequences one frame of bounding boxes through the PE array, one set at a time. Each set holds at most PE_NUM bboxes.
- Per set: computes the active-PE mask, fires the PEs, collects their done flags, then hands the set to registration and waits for it to finish.
- Sits in oflow_core above the PEs and beside the core read FSM. Produces num_of_sets, per-set index and remaining-bbox count for the rest of the core.

Parameters:
- PE_NUM, 24, number of processing elements (bboxes per full set).
- SET_LEN, 4, width of set counters (max 11 sets for 256 bboxes).
- BBOX_LEN, 9, width of bbox counts (0..256).

Ports:
- clk  in  1  core clock.
- reset_N  in  1  asynchronous, active-low reset.
- start_frame  in  1  one-cycle pulse; begins a frame; sampled only in IDLE.
- num_of_bboxes_in_frame  in  BBOX_LEN  bbox count of the frame; sampled with start_frame; values >256 saturate to 256.
- frame_abort  in  1  synchronous abort; returns to IDLE.
- done_pe  in  PE_NUM  per-PE done (pulse or level); bit i = PE i.
- done_registration  in  1  registration finished current set.
- start_pe  out  1  one-cycle pulse; starts the active PEs for the current set.
- active_pe_mask  out  PE_NUM  PEs participating in the current set.
- start_registration  out  1  one-cycle pulse; all active PEs done.
- set_index  out  SET_LEN  index of the current set, 0-based.
- num_of_sets  out  SET_LEN  ceil(n/PE_NUM) for the current frame.
- counter_of_remain_bboxes  out  BBOX_LEN  bboxes not yet completed, including the current set.
- busy  out  1  high whenever state != IDLE.
- frame_done  out  1  one-cycle pulse at end of frame.

Behaviour:
- Reset: all outputs 0; state IDLE; internal sticky done register cleared. Asynchronous reset mid-frame discards the frame; no frame_done is issued.
- All outputs are registered (Moore).

State machine:
- IDLE: on start_frame, latch n (saturated) → LOAD. start_frame in any other state is ignored.
- LOAD (1 cycle):
  - num_of_sets = ceil(n/PE_NUM); counter_of_remain_bboxes = n; set_index = 0.
  - If n == 0 → FRAME_DONE, else → START_SET.
- START_SET (1 cycle):
  - set_bboxes = min(remain, PE_NUM); active_pe_mask = (1<<set_bboxes)-1.
  - start_pe = 1; sticky done register cleared → WAIT_PE.
- WAIT_PE:
  - sticky |= done_pe & active_pe_mask.
  - When sticky == active_pe_mask (including the case where the last bits arrive this cycle), start_registration pulses in the next cycle → REG.
  - done_pe bits outside the mask are ignored. done_pe in START_SET or REG is ignored.
- REG: on done_registration, remain -= set_bboxes and set_index += 1.
  - If the new remain == 0 → FRAME_DONE, else → START_SET.
  - done_registration in any other state is ignored.
- FRAME_DONE (1 cycle): frame_done = 1; active_pe_mask = 0 → IDLE.

Timing and hold rules:
- Latency: start_frame sampled at edge k → start_pe high in cycle k+2.
- Minimum gap between consecutive start_pe pulses: 3 cycles (WAIT_PE, REG, START_SET).
- active_pe_mask and set_index are held stable from START_SET through REG.
- num_of_sets is held until the next LOAD.

frame_abort:
- Highest priority over all other inputs in all states.
- Next state IDLE; start_pe, start_registration, frame_done and busy are 0 next cycle; mask is cleared; counters are held.

Arithmetic:
- remain never underflows (set_bboxes ≤ remain by construction).
- set_index never exceeds num_of_sets-1 while busy.

Decomposition:
- Package oflow_core_sched_pkg holds:
  - PE_NUM, SET_LEN and BBOX_LEN constants;
  - sched_state_t enum {IDLE, LOAD, START_SET, WAIT_PE, REG, FRAME_DONE};
  - function ceil_div_pe(n).
- Sub-module oflow_pe_done_collector holds the sticky PE_NUM-bit register and the compare-against-mask all_done output.
  - Inputs: clear, mask, done_pe.

Test Plan:
- n=48 → num_of_sets=2; two start_pe pulses, each with mask 0xFFFFFF; set_index 0 then 1; remain 48→24→0; frame_done 1 cycle after the 2nd done_registration.
- n=256 → num_of_sets=11; sets 0–9 have mask 0xFFFFFF; set 10 has mask 0x00FFFF and remain=16; exactly one frame_done.
- n=1, done_pe=0x000020 then 0x000001 → first pulse ignored (PE5 inactive); start_registration only after PE0 done; mask 0x000001.
- n=0 → no start_pe, no start_registration; frame_done 2 cycles after start_frame; busy high for exactly 2 cycles. n=300 → behaves as 256.
- n=24: done_pe bits pulsed one at a time over 24 cycles, done_registration asserted early in WAIT_PE, start_frame re-asserted while busy → single start_registration after the last bit; early done_registration and the re-asserted start_frame are ignored.
- Mid-frame interruption:
  - frame_abort in WAIT_PE of set 1 (n=72) → IDLE next cycle, no frame_done; a new start_frame with n=24 completes normally.
  - reset_N low in REG → all outputs 0 immediately (asynchronously).
